pc_sp_bank: RTL and testbench
=============================

Name: pc_sp_bank

Overview:
- Architectural state register stage that holds the program counter, the banked kernel/user stack pointers and the privilege mode.
- Sits directly upstream of the memory address handler. Drives its current_PC, current_SP and is_kernel inputs, and registers the next_PC / next_SP values it returns.
- Adds trap sequencing (software interrupt, external IRQ, exception return) with a saved return PC (EPC).

Parameters:
ADDR_WIDTH, 32, PC/EPC width
DATA_WIDTH, 32, SP width
KERNEL_STACK_TOP, 4096, lowest kernel stack address
KERNEL_STACK_BOTTOM, 6143, highest kernel stack address; kernel SP reset value
USER_STACK_TOP, 6144, lowest user stack address
USER_STACK_BOTTOM, 8191, highest user stack address; user SP reset value
TRAP_VECTOR, 2, PC loaded on trap entry

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low; sampled on rising edge of clock
enable  input  1  pipeline advance; 0 = hold architectural state in RUN
next_PC  input  ADDR_WIDTH  PC computed by address handler
next_SP  input  DATA_WIDTH  SP computed by address handler
swi  input  1  software-interrupt request from decode (valid when enable=1)
eret  input  1  exception-return request from decode (valid when enable=1)
irq  input  1  external interrupt request, level
current_PC  output  ADDR_WIDTH  registered PC
current_SP  output  DATA_WIDTH  SP of active bank (kernel_sp if is_kernel else user_sp)
is_kernel  output  1  registered privilege mode
epc  output  ADDR_WIDTH  saved return address
irq_ack  output  1  one-cycle pulse when a trap is taken
busy  output  1  high in TRAP_ENTER/TRAP_VECTOR; decode must not issue

Behaviour:
- Reset (reset=0 at an edge), from any state including mid-trap:
  - current_PC=0, kernel_sp=KERNEL_STACK_BOTTOM, user_sp=USER_STACK_BOTTOM, is_kernel=1, saved_mode=1, epc=0, irq_ack=0, state=RUN.
- States: RUN, TRAP_ENTER, TRAP_VECTOR.
- RUN, enable=0: all registers hold; irq stays pending (level); swi/eret ignored.
- RUN, enable=1 priority: swi > irq > eret > normal.
  - swi with is_kernel=0, or irq with is_kernel=0:
    - epc<=next_PC, saved_mode<=is_kernel, active-bank SP<=next_SP, PC holds.
    - go TRAP_ENTER.
  - swi with is_kernel=1: treated as normal advance (no nesting).
  - irq with is_kernel=1: not taken; stays pending until user mode.
  - eret with is_kernel=1: current_PC<=epc, is_kernel<=saved_mode, kernel_sp<=next_SP.
  - eret with is_kernel=0: normal advance.
  - normal: current_PC<=next_PC, active-bank SP<=next_SP (bank selected by is_kernel before the edge).
- TRAP_ENTER (1 cycle, independent of enable): is_kernel<=1, irq_ack=1 this cycle, go TRAP_VECTOR.
- TRAP_VECTOR (1 cycle, independent of enable): current_PC<=TRAP_VECTOR, go RUN.
  - First vector instruction fetches 3 cycles after trap acceptance.
- Banking: inactive bank never written. current_SP switches combinationally when is_kernel changes.
- Widths:
  - PC/SP registered as-is, no arithmetic inside; next_PC wrap from the upstream handler is passed through.
  - epc truncation: none (ADDR_WIDTH).
- busy = (state != RUN). irq_ack is registered (high exactly during TRAP_ENTER).

Optional Feature:
- Macro PC_SP_BANK_STACK_GUARD_EN.
- Defined:
  - Any SP write whose value lies outside the active bank's [TOP, BOTTOM] range is suppressed; the bank holds its old value.
  - Sticky output stack_fault (1 bit) is set. It is cleared only by reset (reset value 0).
  - All other state updates in the same cycle proceed.
- Undefined: no range check, no stack_fault port; next_SP always written.

Decomposition:
- Shared package armaria_pkg:
  - state enum (RUN, TRAP_ENTER, TRAP_VECTOR)
  - stack window constants (the four stack bounds) and TRAP_VECTOR, shared with the memory address handler
- One natural sub-module: sp_bank_guard. Takes the mode, a write strobe and next_SP; returns the bank write enables and the range-violation flag (always present internally; flag exported only under the macro).

Test Plan:
- Reset then enable=1, next_PC=1,2,3 -> current_PC 0,1,2,3 on successive cycles; current_SP=6143; is_kernel=1.
- User mode (after eret with epc=10, saved_mode=0), next_SP=8190 -> user_sp=8190, kernel_sp stays 6143; current_SP switches to 8190.
- User mode, next_PC=21, swi=1 -> epc=21; irq_ack high next cycle; is_kernel=1; PC=2 two cycles after acceptance; busy high 2 cycles.
- irq=1 while is_kernel=1 -> no trap. Then eret (epc=21, saved_mode=0) -> PC=21, user mode; irq taken on next enabled cycle.
- enable=0 for 5 cycles with irq=1 in user mode -> all outputs frozen; trap taken on first enable=1.
- Reset asserted during TRAP_ENTER -> next cycle PC=0, is_kernel=1, epc=0, irq_ack=0, state RUN. With PC_SP_BANK_STACK_GUARD_EN defined: next_SP=5000 in user mode -> user_sp unchanged, stack_fault=1 until reset.

Source files
------------

// File: rtl/armaria_pkg.sv
// Shared architectural constants: stack windows, trap vector and the
// pc_sp_bank sequencer state encoding.
package armaria_pkg;

    localparam int unsigned KERNEL_STACK_TOP    = 4096;
    localparam int unsigned KERNEL_STACK_BOTTOM = 6143;
    localparam int unsigned USER_STACK_TOP      = 6144;
    localparam int unsigned USER_STACK_BOTTOM   = 8191;
    localparam int unsigned TRAP_VECTOR         = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN         = 2'd0;
    localparam state_t ST_TRAP_ENTER  = 2'd1;
    localparam state_t ST_TRAP_VECTOR = 2'd2;

endpackage

// File: rtl/pc_sp_bank_if.sv
// Decode/address-handler side bundle of pc_sp_bank.
// stack_fault exists only when PC_SP_BANK_STACK_GUARD_EN is defined.
interface pc_sp_bank_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  enable;
    logic [ADDR_WIDTH-1:0] next_PC;
    logic [DATA_WIDTH-1:0] next_SP;
    logic                  swi;
    logic                  eret;
    logic                  irq;
    logic [ADDR_WIDTH-1:0] current_PC;
    logic [DATA_WIDTH-1:0] current_SP;
    logic                  is_kernel;
    logic [ADDR_WIDTH-1:0] epc;
    logic                  irq_ack;
    logic                  busy;
`ifdef PC_SP_BANK_STACK_GUARD_EN
    logic                  stack_fault;
`endif

    modport master (
        output enable, next_PC, next_SP, swi, eret, irq,
`ifdef PC_SP_BANK_STACK_GUARD_EN
        input  stack_fault,
`endif
        input  current_PC, current_SP, is_kernel, epc, irq_ack, busy
    );

    modport slave (
        input  enable, next_PC, next_SP, swi, eret, irq,
`ifdef PC_SP_BANK_STACK_GUARD_EN
        output stack_fault,
`endif
        output current_PC, current_SP, is_kernel, epc, irq_ack, busy
    );

endinterface

// File: rtl/sp_bank_guard.sv
// Steers an SP write into the active bank; with PC_SP_BANK_STACK_GUARD_EN
// out-of-window writes are dropped. The violation flag is always produced.
module sp_bank_guard
    import armaria_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_kernel_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] sp_i,
    output logic                  kernel_we_o,
    output logic                  user_we_o,
    output logic                  violation_o
);
    logic in_kernel_win;
    logic in_user_win;
    logic in_active_win;
    logic wr_allowed;

    assign in_kernel_win = (sp_i >= DATA_WIDTH'(KERNEL_STACK_TOP)) &&
                           (sp_i <= DATA_WIDTH'(KERNEL_STACK_BOTTOM));
    assign in_user_win   = (sp_i >= DATA_WIDTH'(USER_STACK_TOP)) &&
                           (sp_i <= DATA_WIDTH'(USER_STACK_BOTTOM));
    assign in_active_win = is_kernel_i ? in_kernel_win : in_user_win;
    assign violation_o   = wr_i && !in_active_win;

`ifdef PC_SP_BANK_STACK_GUARD_EN
    assign wr_allowed = wr_i && in_active_win;
`else
    assign wr_allowed = wr_i;
`endif

    // The inactive bank is never written.
    assign kernel_we_o = wr_allowed && is_kernel_i;
    assign user_we_o   = wr_allowed && !is_kernel_i;

endmodule

// File: rtl/pc_sp_bank.sv
// Architectural PC, banked kernel/user SP and privilege mode, with trap entry/return.
// Build option PC_SP_BANK_STACK_GUARD_EN: stack-window check and sticky stack_fault.
module pc_sp_bank
    import armaria_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic         clock,
    input logic         reset,
    pc_sp_bank_if.slave bus
);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d;
    logic [DATA_WIDTH-1:0] kernel_sp_q, user_sp_q;
    logic                  is_kernel_q, is_kernel_d;
    logic                  saved_mode_q, saved_mode_d;
    logic                  irq_ack_q, irq_ack_d;
    logic                  sp_wr;
    logic                  kernel_we, user_we;
    logic                  range_violation;

    sp_bank_guard #(.DATA_WIDTH(DATA_WIDTH)) u_guard (
        .is_kernel_i (is_kernel_q),
        .wr_i        (sp_wr),
        .sp_i        (bus.next_SP),
        .kernel_we_o (kernel_we),
        .user_we_o   (user_we),
        .violation_o (range_violation)
    );

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no latch is inferred.
        state_d      = state_q;
        pc_d         = pc_q;
        epc_d        = epc_q;
        is_kernel_d  = is_kernel_q;
        saved_mode_d = saved_mode_q;
        irq_ack_d    = 1'b0;
        sp_wr        = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.enable) begin
                    sp_wr = 1'b1;
                    // In kernel mode swi is a plain advance and irq stays pending.
                    if (!is_kernel_q && (bus.swi || bus.irq)) begin
                        epc_d        = bus.next_PC;
                        saved_mode_d = is_kernel_q;
                        irq_ack_d    = 1'b1;
                        state_d      = ST_TRAP_ENTER;
                    end else if (is_kernel_q && !bus.swi && bus.eret) begin
                        pc_d        = epc_q;
                        is_kernel_d = saved_mode_q;
                    end else begin
                        pc_d = bus.next_PC;
                    end
                end
            end
            ST_TRAP_ENTER: begin
                is_kernel_d = 1'b1;
                state_d     = ST_TRAP_VECTOR;
            end
            ST_TRAP_VECTOR: begin
                pc_d    = ADDR_WIDTH'(TRAP_VECTOR);
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            pc_q         <= '0;
            epc_q        <= '0;
            kernel_sp_q  <= DATA_WIDTH'(KERNEL_STACK_BOTTOM);
            user_sp_q    <= DATA_WIDTH'(USER_STACK_BOTTOM);
            is_kernel_q  <= 1'b1;
            saved_mode_q <= 1'b1;
            irq_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            is_kernel_q  <= is_kernel_d;
            saved_mode_q <= saved_mode_d;
            irq_ack_q    <= irq_ack_d;
            if (kernel_we) kernel_sp_q <= bus.next_SP;
            if (user_we)   user_sp_q   <= bus.next_SP;
        end
    end

`ifdef PC_SP_BANK_STACK_GUARD_EN
    logic stack_fault_q;

    always_ff @(posedge clock) begin
        if (!reset) stack_fault_q <= 1'b0;
        else if (range_violation) stack_fault_q <= 1'b1;
    end

    assign bus.stack_fault = stack_fault_q;
`else
    logic unused_range_violation;
    assign unused_range_violation = range_violation;
`endif

    assign bus.current_PC = pc_q;
    assign bus.current_SP = is_kernel_q ? kernel_sp_q : user_sp_q;
    assign bus.is_kernel  = is_kernel_q;
    assign bus.epc        = epc_q;
    assign bus.irq_ack    = irq_ack_q;
    assign bus.busy       = (state_q != ST_RUN);

endmodule

// File: tb/tb_pc_sp_bank.sv
// Scoreboarded random + directed bench for pc_sp_bank against a behavioural model.
// Honors PC_SP_BANK_STACK_GUARD_EN when the RTL is built with it.
module tb_pc_sp_bank;

    localparam logic [31:0] K_TOP   = 32'd4096;
    localparam logic [31:0] K_BOT   = 32'd6143;
    localparam logic [31:0] U_TOP   = 32'd6144;
    localparam logic [31:0] U_BOT   = 32'd8191;
    localparam logic [31:0] TRAP_PC = 32'd2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pc_sp_bank_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    pc_sp_bank #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] sp;
        logic [31:0] epc;
        logic        mode;
        logic        ack;
        logic        busy;
        logic        fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: phase counts the remaining trap-sequence cycles.
    logic [31:0] m_pc, m_ksp, m_usp, m_epc;
    logic        m_mode, m_saved, m_ack, m_fault;
    int          m_phase;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic sp_in_window(input logic mode, input logic [31:0] sp);
`ifdef PC_SP_BANK_STACK_GUARD_EN
        return mode ? (sp >= K_TOP && sp <= K_BOT) : (sp >= U_TOP && sp <= U_BOT);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_edge(input logic rst, input logic en, input logic swi,
                              input logic eret, input logic irq,
                              input logic [31:0] npc, input logic [31:0] nsp);
        logic take_trap, take_ret;
        m_ack = 1'b0;
        if (!rst) begin
            m_pc = 0; m_ksp = K_BOT; m_usp = U_BOT; m_epc = 0;
            m_mode = 1'b1; m_saved = 1'b1; m_fault = 1'b0; m_phase = 0;
        end else if (m_phase == 2) begin
            m_mode  = 1'b1;
            m_phase = 1;
        end else if (m_phase == 1) begin
            m_pc    = TRAP_PC;
            m_phase = 0;
        end else if (en) begin
            take_trap = !m_mode && (swi || irq);
            take_ret  = m_mode && !swi && eret;
            if (!sp_in_window(m_mode, nsp)) m_fault = 1'b1;
            else if (m_mode) m_ksp = nsp;
            else m_usp = nsp;
            if (take_trap) begin
                m_epc = npc; m_saved = m_mode; m_ack = 1'b1; m_phase = 2;
            end else if (take_ret) begin
                m_pc = m_epc; m_mode = m_saved;
            end else begin
                m_pc = npc;
            end
        end
    endtask

    // Called at a falling edge: drive, predict the post-edge outputs, queue them.
    task automatic step(input logic rst, input logic en, input logic swi, input logic eret,
                        input logic irq, input logic [31:0] npc, input logic [31:0] nsp);
        exp_t e;
        reset       = rst;
        bus.enable  = en;
        bus.swi     = swi;
        bus.eret    = eret;
        bus.irq     = irq;
        bus.next_PC = npc;
        bus.next_SP = nsp;
        model_edge(rst, en, swi, eret, irq, npc, nsp);
        e.pc    = m_pc;
        e.sp    = m_mode ? m_ksp : m_usp;
        e.epc   = m_epc;
        e.mode  = m_mode;
        e.ack   = m_ack;
        e.busy  = (m_phase != 0);
        e.fault = m_fault;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("current_PC", bus.current_PC, e.pc);
                check("current_SP", bus.current_SP, e.sp);
                check("epc",        bus.epc,        e.epc);
                check("is_kernel",  {31'd0, bus.is_kernel}, {31'd0, e.mode});
                check("irq_ack",    {31'd0, bus.irq_ack},   {31'd0, e.ack});
                check("busy",       {31'd0, bus.busy},      {31'd0, e.busy});
`ifdef PC_SP_BANK_STACK_GUARD_EN
                check("stack_fault", {31'd0, bus.stack_fault}, {31'd0, e.fault});
`endif
            end
        end
    end

    initial begin : stimulus
        logic        r_en, r_swi, r_eret, r_irq;
        logic [31:0] r_pc, r_sp;
        bus.enable = 1'b0; bus.swi = 1'b0; bus.eret = 1'b0; bus.irq = 1'b0;
        bus.next_PC = '0; bus.next_SP = '0;
        @(negedge clock);

        step(0, 0, 0, 0, 0, 32'd0, 32'd0);
        step(0, 1, 1, 1, 1, 32'd99, 32'd99);
        step(1, 1, 0, 0, 0, 32'd1, K_BOT);
        step(1, 1, 0, 0, 0, 32'd2, K_BOT);
        step(1, 1, 0, 0, 0, 32'd3, K_BOT);

        // Reset leaves no architectural path into user mode; seed the saved context.
        force dut.epc_q = 32'd10;
        force dut.saved_mode_q = 1'b0;
        m_epc = 32'd10; m_saved = 1'b0;
        fork begin @(posedge clock); #2; release dut.epc_q; release dut.saved_mode_q; end join_none
        step(1, 1, 0, 1, 0, 32'd4, K_BOT);
        step(1, 1, 0, 0, 0, 32'd11, 32'd8190);
        step(1, 1, 1, 0, 0, 32'd21, 32'd8190);
        step(1, 0, 0, 0, 0, 32'd22, 32'd0);
        step(1, 0, 0, 0, 0, 32'd23, 32'd0);
        step(1, 1, 0, 0, 1, 32'd3, 32'd6000);
        step(1, 1, 0, 1, 1, 32'd4, 32'd6000);
        repeat (5) step(1, 0, 1, 1, 1, 32'd77, 32'd1);
        step(1, 1, 0, 0, 1, 32'd30, 32'd8100);
        step(1, 1, 0, 1, 0, 32'd31, 32'd5000);
        step(1, 1, 1, 0, 0, 32'd32, 32'd5001);

        repeat (400) begin
            r_en   = ($urandom_range(0, 9) < 8);
            r_swi  = ($urandom_range(0, 9) == 0);
            r_eret = ($urandom_range(0, 5) == 0);
            r_irq  = ($urandom_range(0, 6) == 0);
            r_pc   = $urandom();
            if ($urandom_range(0, 15) == 0) r_sp = $urandom();
            else if (m_mode) r_sp = $urandom_range(K_BOT, K_TOP);
            else r_sp = $urandom_range(U_BOT, U_TOP);
            step(1, r_en, r_swi, r_eret, r_irq, r_pc, r_sp);
        end

        repeat (3) step(1, 0, 0, 0, 0, 32'd0, 32'd0);
        force dut.epc_q = 32'd50;
        force dut.saved_mode_q = 1'b0;
        m_epc = 32'd50; m_saved = 1'b0;
        fork begin @(posedge clock); #2; release dut.epc_q; release dut.saved_mode_q; end join_none
        step(1, 1, 0, 1, 0, 32'd60, m_mode ? K_BOT : U_BOT);
        step(1, 1, 1, 0, 0, 32'd77, U_BOT);
        step(0, 1, 0, 0, 0, 32'd78, U_BOT);
        step(1, 1, 0, 0, 0, 32'd5, 32'd6100);

        force dut.epc_q = 32'd60;
        force dut.saved_mode_q = 1'b0;
        m_epc = 32'd60; m_saved = 1'b0;
        fork begin @(posedge clock); #2; release dut.epc_q; release dut.saved_mode_q; end join_none
        step(1, 1, 0, 1, 0, 32'd6, 32'd6100);
        step(1, 1, 0, 0, 0, 32'd61, 32'd5000);
        step(1, 1, 0, 0, 0, 32'd62, 32'd8000);
        step(1, 1, 0, 0, 0, 32'd63, 32'd9000);
        step(0, 0, 0, 0, 0, 32'd0, 32'd0);
        step(1, 1, 0, 0, 0, 32'd64, K_TOP);

        @(posedge clock);
        #3;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
